// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, branch redirect flush, dmem wait
// with timeout to a sticky bus error, and a saturating count of stalled fetch cycles.
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             ex_memRead,
  input  logic [4:0]       ex_rd,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_bubble,
  output logic             bus_err,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_L = 8'(TIMEOUT);

  state_t     state, state_nxt;
  logic [7:0] to_cnt, to_cnt_nxt;
  logic       load_use;
  logic       release_eval;

  assign load_use = ex_memRead && (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt     = state;
    to_cnt_nxt    = to_cnt;
    release_eval  = 1'b0;
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    ex_mem_en     = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_wb_bubble = 1'b0;
    bus_err       = 1'b0;

    case (state)
      RUN: begin
        if (mem_req && !dmem_ready) begin
          {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b0000;
          mem_wb_bubble = 1'b1;
          state_nxt     = MEM_WAIT;
          to_cnt_nxt    = 8'd1;
        end else begin
          release_eval = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!dmem_ready) begin
          {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b0000;
          mem_wb_bubble = 1'b1;
          if (to_cnt == TIMEOUT_L) state_nxt = ERROR;
          else                     to_cnt_nxt = to_cnt + 8'd1;
        end else begin
          // A ready in the timeout cycle still releases the access.
          release_eval = 1'b1;
          state_nxt    = RUN;
        end
      end
      default: begin
        {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b0000;
        mem_wb_bubble = 1'b1;
        bus_err       = 1'b1;
        state_nxt     = ERROR;
      end
    endcase

    // EX/ID were frozen while waiting, so redirect and load-use are resolved only here.
    if (release_eval) begin
      if (ex_redirect) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end

    if (rst) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b0000;
      if_id_flush   = 1'b0;
      id_ex_flush   = 1'b0;
      mem_wb_bubble = 1'b1;
      bus_err       = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RUN;
      to_cnt       <= 8'd0;
      stall_cycles <= '0;
    end else begin
      state  <= state_nxt;
      to_cnt <= to_cnt_nxt;
      if (!pc_en && (stall_cycles != {CNT_W{1'b1}}))
        stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (default and TIMEOUT=4/CNT_W=4) checked each
// cycle against a rule-level model, plus directed scenarios with literal expectations.
module tb_pipe_hazard_ctrl;

  // Control vector bit order: pc_en, if_id_en, id_ex_en, ex_mem_en,
  // if_id_flush, id_ex_flush, mem_wb_bubble, bus_err.
  localparam logic [7:0] C_RESET = 8'b0000_0010;
  localparam logic [7:0] C_FROZE = 8'b0000_0010;
  localparam logic [7:0] C_ERROR = 8'b0000_0011;
  localparam logic [7:0] C_RUN   = 8'b1111_0000;
  localparam logic [7:0] C_FLUSH = 8'b1111_1100;
  localparam logic [7:0] C_LU    = 8'b0011_0100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       ex_memRead, ex_redirect, mem_req, dmem_ready;

  wire [7:0]  ctl0, ctl1;
  wire [15:0] sc0;
  wire [3:0]  sc1;

  pipe_hazard_ctrl u_d0 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_memRead(ex_memRead),
    .ex_rd(ex_rd), .ex_redirect(ex_redirect), .mem_req(mem_req), .dmem_ready(dmem_ready),
    .pc_en(ctl0[7]), .if_id_en(ctl0[6]), .id_ex_en(ctl0[5]), .ex_mem_en(ctl0[4]),
    .if_id_flush(ctl0[3]), .id_ex_flush(ctl0[2]), .mem_wb_bubble(ctl0[1]),
    .bus_err(ctl0[0]), .stall_cycles(sc0)
  );

  pipe_hazard_ctrl #(.TIMEOUT(4), .CNT_W(4)) u_d1 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_memRead(ex_memRead),
    .ex_rd(ex_rd), .ex_redirect(ex_redirect), .mem_req(mem_req), .dmem_ready(dmem_ready),
    .pc_en(ctl1[7]), .if_id_en(ctl1[6]), .id_ex_en(ctl1[5]), .ex_mem_en(ctl1[4]),
    .if_id_flush(ctl1[3]), .id_ex_flush(ctl1[2]), .mem_wb_bubble(ctl1[1]),
    .bus_err(ctl1[0]), .stall_cycles(sc1)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: an access is "waiting" for some number of cycles, after which the
  // bus is declared broken; stalled fetch cycles are simply tallied up to a ceiling.
  typedef struct {
    bit waiting;
    bit broken;
    int waited;
    int stalls;
  } mstate_t;

  mstate_t m[2];
  mstate_t mn[2];
  int      tmo[2]  = '{255, 4};
  int      smax[2] = '{65535, 15};

  initial begin
    for (int k = 0; k < 2; k++) begin
      m[k]  = '{0, 0, 0, 0};
      mn[k] = '{0, 0, 0, 0};
    end
  end

  task automatic model_step(input int k, output logic [7:0] e_ctl, output int e_stall);
    bit hazard;
    hazard = ex_memRead && (ex_rd != 0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    if (rst) begin
      m[k]    = '{0, 0, 0, 0};
      mn[k]   = m[k];
      e_ctl   = C_RESET;
      e_stall = 0;
      return;
    end
    e_stall = m[k].stalls;
    mn[k]   = m[k];
    if (m[k].broken) begin
      e_ctl = C_ERROR;
    end else if (m[k].waiting && !dmem_ready) begin
      e_ctl = C_FROZE;
      if (m[k].waited == tmo[k]) begin
        mn[k].broken  = 1;
        mn[k].waiting = 0;
      end else begin
        mn[k].waited = m[k].waited + 1;
      end
    end else if (!m[k].waiting && mem_req && !dmem_ready) begin
      e_ctl         = C_FROZE;
      mn[k].waiting = 1;
      mn[k].waited  = 1;
    end else begin
      mn[k].waiting = 0;
      if (ex_redirect) e_ctl = C_FLUSH;
      else if (hazard) e_ctl = C_LU;
      else             e_ctl = C_RUN;
    end
    if (!e_ctl[7] && m[k].stalls < smax[k]) mn[k].stalls = m[k].stalls + 1;
  endtask

  always @(negedge clk) begin
    logic [7:0] ec;
    int         es;
    model_step(0, ec, es);
    check("d0_ctl", {24'd0, ctl0}, {24'd0, ec});
    check("d0_stall", {16'd0, sc0}, es);
    model_step(1, ec, es);
    check("d1_ctl", {24'd0, ctl1}, {24'd0, ec});
    check("d1_stall", {28'd0, sc1}, es);
  end

  always @(posedge clk) begin
    m <= mn;
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1 = 5'd1; id_rs2 = 5'd2; ex_rd = 5'd3;
    ex_memRead = 1'b0; ex_redirect = 1'b0; mem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    next();
    next();
    rst = 1'b0;
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    next(); next(); #2;
    check("reset_ctl", {24'd0, ctl0}, {24'd0, C_RESET});
    check("reset_stall", {16'd0, sc0}, 32'd0);

    next(); rst = 1'b0; #2;
    check("run_default", {24'd0, ctl0}, {24'd0, C_RUN});

    // Load-use on rs2: one bubble, stall count 0 -> 1.
    next(); ex_memRead = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_rs1 = 5'd7; #2;
    check("lu_ctl", {24'd0, ctl0}, {24'd0, C_LU});
    check("lu_stall_before", {16'd0, sc0}, 32'd0);
    next(); idle(); #2;
    check("lu_after", {24'd0, ctl0}, {24'd0, C_RUN});
    check("lu_stall_after", {16'd0, sc0}, 32'd1);

    // x0 destination never creates a hazard.
    next(); ex_memRead = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; #2;
    check("lu_x0", {24'd0, ctl0}, {24'd0, C_RUN});

    // Three not-ready cycles then release.
    next(); do_reset(); mem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2; check("memwait_frozen", {24'd0, ctl0}, {24'd0, C_FROZE});
      next();
    end
    dmem_ready = 1'b1; #2;
    check("memwait_release", {24'd0, ctl0}, {24'd0, C_RUN});
    check("memwait_stall", {16'd0, sc0}, 32'd3);

    // Redirect held through the wait is only acted on at release.
    next(); do_reset(); mem_req = 1'b1; dmem_ready = 1'b0; ex_redirect = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2; check("redir_wait_noflush", {24'd0, ctl0}, {24'd0, C_FROZE});
      next();
    end
    dmem_ready = 1'b1; #2;
    check("redir_release_flush", {24'd0, ctl0}, {24'd0, C_FLUSH});

    // Redirect beats load-use in the same cycle.
    next(); idle(); ex_redirect = 1'b1; ex_memRead = 1'b1; ex_rd = 5'd4; id_rs1 = 5'd4; #2;
    check("redir_over_lu", {24'd0, ctl0}, {24'd0, C_FLUSH});

    // Small instance: timeout after 4 wait cycles, sticky error, saturation, reset recovery.
    next(); do_reset(); mem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #2; check("to4_no_err_yet", {31'd0, ctl1[0]}, 32'd0);
      next();
    end
    #2; check("to4_error", {24'd0, ctl1}, {24'd0, C_ERROR});
    next(); mem_req = 1'b0; dmem_ready = 1'b1; #2;
    check("to4_sticky", {24'd0, ctl1}, {24'd0, C_ERROR});
    repeat (20) next();
    #2; check("d1_stall_sat", {28'd0, sc1}, 32'd15);
    rst = 1'b1; #1;
    check("to4_rst_ctl", {24'd0, ctl1}, {24'd0, C_RESET});
    check("to4_rst_stall", {28'd0, sc1}, 32'd0);
    next(); rst = 1'b0; #2;
    check("to4_after_rst", {24'd0, ctl1}, {24'd0, C_RUN});

    // Ready arriving in the timeout cycle wins.
    next(); do_reset(); mem_req = 1'b1; dmem_ready = 1'b0;
    repeat (4) next();
    dmem_ready = 1'b1; #2;
    check("to4_ready_wins", {24'd0, ctl1}, {24'd0, C_RUN});
    next(); mem_req = 1'b0; #2;
    check("to4_no_err", {24'd0, ctl1}, {24'd0, C_RUN});

    // Default instance times out only after 255 wait cycles.
    next(); do_reset(); mem_req = 1'b1; dmem_ready = 1'b0;
    repeat (255) next();
    #2; check("to255_edge", {31'd0, ctl0[0]}, 32'd0);
    next(); #2;
    check("to255_error", {24'd0, ctl0}, {24'd0, C_ERROR});

    // Random traffic against the model.
    next(); do_reset();
    repeat (3000) begin
      rst         = ($urandom_range(0, 199) == 0);
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      ex_rd       = 5'($urandom_range(0, 3));
      ex_memRead  = ($urandom_range(0, 1) == 1);
      ex_redirect = ($urandom_range(0, 9) < 2);
      mem_req     = ($urandom_range(0, 9) < 4);
      dmem_ready  = ($urandom_range(0, 9) < 7);
      next();
    end
    rst = 1'b0;
    idle();
    next();
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
